// File: rtl/snn_mem_pkg.sv
// Shared definitions for the SNN memory controller.
//   - default dimension constants used as parameter defaults
//   - req_op_e : request opcode encoding (codes 6-7 are illegal)
//   - state_e  : controller FSM states
//   - addr_width / max_int : constant helper functions for sizing
package snn_mem_pkg;

  localparam int DEF_TIMESTEPS = 10;
  localparam int DEF_NUM_CH    = 1;
  localparam int DEF_IF_ROWS   = 5;
  localparam int DEF_IF_COLS   = 5;
  localparam int DEF_F_ROWS    = 3;
  localparam int DEF_F_COLS    = 3;
  localparam int DEF_OF_ROWS   = 3;
  localparam int DEF_OF_COLS   = 3;
  localparam int DEF_F_WIDTH   = 8;
  localparam int DEF_V_WIDTH   = 8;

  typedef enum logic [2:0] {
    OP_RD_VPOT = 3'd0,
    OP_RD_ISPK = 3'd1,
    OP_RD_FILT = 3'd2,
    OP_WR_VPOT = 3'd3,
    OP_WR_OSPK = 3'd4,
    OP_RD_OSPK = 3'd5
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Address width for an array of 'depth' entries (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/snn_mem_bank.sv
// Parametrised storage array: synchronous write, registered read.
//   clk, rst_n      : clock, asynchronous active-low reset
//   we/waddr/wdata  : write port, takes effect on the rising edge
//   re/raddr        : read enable/address; rdata updates on the edge after re
//   rdata           : registered read data, held while re is low
// CLEAR_ON_RST selects whether the array contents are cleared by reset.
// The read register is always reset so the response path starts at zero.
module snn_mem_bank #(
  parameter int DEPTH        = 9,
  parameter int WIDTH        = 8,
  parameter int AW           = 4,
  parameter bit CLEAR_ON_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  generate
    if (CLEAR_ON_RST) begin : g_clear
      // NOTE: only arrays whose contents must be zero after reset get a reset
      // branch; the others stay reset-free so they can map onto plain RAM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
          mem_q[waddr] <= wdata;
        end
      end
    end else begin : g_keep
      always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
      end
    end
  endgenerate

  // A write and a read to the same entry in one cycle return the old value,
  // because the read samples mem_q before the write lands.
  always_comb begin
    rdata_d = re ? mem_q[raddr] : rdata_q;
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/snn_mem_ctrl.sv
// Memory controller for a convolutional SNN layer.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   ld_valid/ld_sel/ld_addr/ld_data: preload of filter (sel=0) or ifmap (sel=1)
//   req_valid/req_ready/req_op/req_ch/req_row/req_col/req_wdata : requests
//   rsp_valid/rsp_ready/rsp_data/rsp_err : read responses
//   ts_valid/ts_ready/ts/done      : timestep advance and completion
// Storage: filter [ch][row][col], ifmap bits [t][row][col], V_pot [ch][row][col],
// output spikes [t][ch][row][col]. V_pot and output spikes clear on reset.
module snn_mem_ctrl
  import snn_mem_pkg::*;
#(
  parameter int TIMESTEPS = DEF_TIMESTEPS,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int IF_ROWS   = DEF_IF_ROWS,
  parameter int IF_COLS   = DEF_IF_COLS,
  parameter int F_ROWS    = DEF_F_ROWS,
  parameter int F_COLS    = DEF_F_COLS,
  parameter int OF_ROWS   = DEF_OF_ROWS,
  parameter int OF_COLS   = DEF_OF_COLS,
  parameter int F_WIDTH   = DEF_F_WIDTH,
  parameter int V_WIDTH   = DEF_V_WIDTH,
  localparam int D_W      = max_int(F_WIDTH, V_WIDTH),
  localparam int TS_W     = addr_width(TIMESTEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic               ld_sel,
  input  logic [15:0]        ld_addr,
  input  logic [F_WIDTH-1:0] ld_data,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [7:0]         req_ch,
  input  logic [7:0]         req_row,
  input  logic [7:0]         req_col,
  input  logic [V_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_W-1:0]     rsp_data,
  output logic               rsp_err,
  input  logic               ts_valid,
  output logic               ts_ready,
  output logic [TS_W-1:0]    ts,
  output logic               done
);

  localparam int FILT_DEPTH = NUM_CH * F_ROWS * F_COLS;
  localparam int IFM_DEPTH  = TIMESTEPS * IF_ROWS * IF_COLS;
  localparam int VPOT_DEPTH = NUM_CH * OF_ROWS * OF_COLS;
  localparam int OSPK_DEPTH = TIMESTEPS * VPOT_DEPTH;
  localparam int FILT_AW    = addr_width(FILT_DEPTH);
  localparam int IFM_AW     = addr_width(IFM_DEPTH);
  localparam int VPOT_AW    = addr_width(VPOT_DEPTH);
  localparam int OSPK_AW    = addr_width(OSPK_DEPTH);

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  req_op_e           rsp_op_q, rsp_op_d;
  logic              rsp_err_q, rsp_err_d;

  req_op_e           op;
  logic              req_fire, ts_fire, ts_last;
  logic              is_read, addr_ok;
  logic              filt_re, ifm_re, vpot_re, vpot_we, ospk_re, ospk_we;
  logic              filt_ld, ifm_ld;
  logic [31:0]       ld_idx, ch_i, row_i, col_i, ts_i;
  logic [31:0]       filt_idx, ifm_idx, vpot_idx, ospk_idx;
  logic              of_ok, f_ok, if_ok;
  logic [F_WIDTH-1:0] filt_rd;
  logic [V_WIDTH-1:0] vpot_rd;
  logic              ifm_rd, ospk_rd;

  // ---------------- preload decode ----------------
  assign ld_idx = 32'(ld_addr);
  assign filt_ld = ld_valid && !ld_sel && (ld_idx < FILT_DEPTH);
  assign ifm_ld  = ld_valid &&  ld_sel && (ld_idx < IFM_DEPTH);

  // ---------------- request decode ----------------
  assign ch_i  = 32'(req_ch);
  assign row_i = 32'(req_row);
  assign col_i = 32'(req_col);
  assign ts_i  = 32'(ts_q);

  assign filt_idx = (ch_i * F_ROWS + row_i) * F_COLS + col_i;
  assign ifm_idx  = (ts_i * IF_ROWS + row_i) * IF_COLS + col_i;
  assign vpot_idx = (ch_i * OF_ROWS + row_i) * OF_COLS + col_i;
  // Spike accesses always address the current (pre-increment) timestep.
  assign ospk_idx = ts_i * VPOT_DEPTH + vpot_idx;

  assign of_ok = (ch_i < NUM_CH) && (row_i < OF_ROWS) && (col_i < OF_COLS);
  assign f_ok  = (ch_i < NUM_CH) && (row_i < F_ROWS)  && (col_i < F_COLS);
  assign if_ok = (row_i < IF_ROWS) && (col_i < IF_COLS);

  assign req_ready = (state_q == ST_IDLE);
  assign ts_ready  = (state_q != ST_DONE);
  assign req_fire  = req_valid && req_ready;
  assign ts_fire   = ts_valid && ts_ready;
  assign ts_last   = (ts_q == TS_W'(TIMESTEPS - 1));

  // Illegal opcodes are answered like a read that failed, so the requester
  // always sees an error instead of a silent drop.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    op      = req_op_e'(req_op);
    is_read = 1'b0;
    addr_ok = 1'b0;
    filt_re = 1'b0;
    ifm_re  = 1'b0;
    vpot_re = 1'b0;
    vpot_we = 1'b0;
    ospk_re = 1'b0;
    ospk_we = 1'b0;
    case (op)
      OP_RD_VPOT: begin is_read = 1'b1; addr_ok = of_ok; vpot_re = req_fire && of_ok; end
      OP_RD_ISPK: begin is_read = 1'b1; addr_ok = if_ok; ifm_re  = req_fire && if_ok; end
      OP_RD_FILT: begin is_read = 1'b1; addr_ok = f_ok;  filt_re = req_fire && f_ok;  end
      OP_RD_OSPK: begin is_read = 1'b1; addr_ok = of_ok; ospk_re = req_fire && of_ok; end
      OP_WR_VPOT: vpot_we = req_fire && of_ok;
      OP_WR_OSPK: ospk_we = req_fire && of_ok;
      default:    is_read = 1'b1;
    endcase
  end

  // ---------------- FSM and timestep ----------------
  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    rsp_op_d  = rsp_op_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire && is_read) begin
          state_d   = ST_RESP;
          rsp_op_d  = op;
          rsp_err_d = !addr_ok;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    // The final advance wins over any pending response: the run is over.
    if (ts_fire) begin
      if (ts_last) state_d = ST_DONE;
      else         ts_d    = ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ts_q      <= '0;
      rsp_op_q  <= OP_RD_VPOT;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_d;
      rsp_op_q  <= rsp_op_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // ---------------- response ----------------
  // Bank read registers only load on an accepted read, and none is accepted
  // outside IDLE, so the response holds while waiting for rsp_ready.
  always_comb begin
    rsp_data = '0;
    if (!rsp_err_q) begin
      case (rsp_op_q)
        OP_RD_VPOT: rsp_data = D_W'(vpot_rd);
        OP_RD_FILT: rsp_data = D_W'(filt_rd);
        OP_RD_ISPK: rsp_data = D_W'(ifm_rd);
        OP_RD_OSPK: rsp_data = D_W'(ospk_rd);
        default:    rsp_data = '0;
      endcase
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_err_q;
  assign ts        = ts_q;
  assign done      = (state_q == ST_DONE);

  // ---------------- storage ----------------
  snn_mem_bank #(.DEPTH(FILT_DEPTH), .WIDTH(F_WIDTH), .AW(FILT_AW), .CLEAR_ON_RST(1'b0)) u_filt (
    .clk(clk), .rst_n(rst_n),
    .we(filt_ld), .waddr(FILT_AW'(ld_idx)), .wdata(ld_data),
    .re(filt_re), .raddr(FILT_AW'(filt_idx)), .rdata(filt_rd)
  );

  snn_mem_bank #(.DEPTH(IFM_DEPTH), .WIDTH(1), .AW(IFM_AW), .CLEAR_ON_RST(1'b0)) u_ifm (
    .clk(clk), .rst_n(rst_n),
    .we(ifm_ld), .waddr(IFM_AW'(ld_idx)), .wdata(ld_data[0]),
    .re(ifm_re), .raddr(IFM_AW'(ifm_idx)), .rdata(ifm_rd)
  );

  snn_mem_bank #(.DEPTH(VPOT_DEPTH), .WIDTH(V_WIDTH), .AW(VPOT_AW), .CLEAR_ON_RST(1'b1)) u_vpot (
    .clk(clk), .rst_n(rst_n),
    .we(vpot_we), .waddr(VPOT_AW'(vpot_idx)), .wdata(req_wdata),
    .re(vpot_re), .raddr(VPOT_AW'(vpot_idx)), .rdata(vpot_rd)
  );

  // Output spikes are write-one: the stored value is always 1.
  snn_mem_bank #(.DEPTH(OSPK_DEPTH), .WIDTH(1), .AW(OSPK_AW), .CLEAR_ON_RST(1'b1)) u_ospk (
    .clk(clk), .rst_n(rst_n),
    .we(ospk_we), .waddr(OSPK_AW'(ospk_idx)), .wdata(1'b1),
    .re(ospk_re), .raddr(OSPK_AW'(ospk_idx)), .rdata(ospk_rd)
  );

endmodule

// File: tb/tb_snn_mem_ctrl.sv
// Self-checking bench for snn_mem_ctrl with default parameters.
// Read expectations go into a queue when the request is driven and are
// compared when the response appears.
module tb_snn_mem_ctrl;
  import snn_mem_pkg::*;

  logic       clk, rst_n;
  logic       ld_valid, ld_sel;
  logic [15:0] ld_addr;
  logic [7:0] ld_data;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [7:0] req_ch, req_row, req_col, req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;
  logic       ts_valid, ts_ready, done;
  logic [3:0] ts;

  snn_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_ch(req_ch), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts(ts), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] ch, row, col, wdata;
    logic       rd;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] ch, input logic [7:0] row,
                              input logic [7:0] col, input logic [7:0] wd, input logic rd,
                              input logic [7:0] ed, input logic ee);
    vec_t v;
    v.op = op; v.ch = ch; v.row = row; v.col = col; v.wdata = wd;
    v.rd = rd; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic preload(input logic sel, input logic [15:0] addr, input logic [7:0] data);
    ld_valid = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] ch, input logic [7:0] row,
                      input logic [7:0] col, input logic [7:0] wd, input logic adv,
                      input logic rd, input logic [7:0] ed, input logic ee);
    int w = 0;
    while (!req_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_ready: req_ready got 0 expected 1");
      return;
    end
    req_valid = 1'b1; req_op = op; req_ch = ch; req_row = row; req_col = col;
    req_wdata = wd; ts_valid = adv;
    if (rd) exp_q.push_back('{data: ed, err: ee});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; ts_valid = 1'b0;
  endtask

  // Expects the response on the falling edge right after the accept edge.
  task automatic get_rsp(input string name, input int hold);
    int   waited = 0;
    exp_t e;
    while (!rsp_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid || exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: rsp_valid got %0b expected 1", name, rsp_valid);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    check({name, " latency"}, 32'(waited), 32'd0);
    check({name, " data"}, 32'(rsp_data), 32'(e.data));
    check({name, " err"}, 32'(rsp_err), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({name, " hold data"}, 32'(rsp_data), 32'(e.data));
      check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic rd(input string name, input logic [2:0] op, input logic [7:0] ch,
                    input logic [7:0] row, input logic [7:0] col,
                    input logic [7:0] ed, input logic ee);
    send(op, ch, row, col, 8'd0, 1'b0, 1'b1, ed, ee);
    get_rsp(name, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 expected less");
    $fatal(1, "watchdog");
  end

  initial begin
    int adv;
    rst_n = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_op = '0; req_ch = '0; req_row = '0; req_col = '0;
    req_wdata = '0; rsp_ready = 1'b0; ts_valid = 1'b0;

    vecs[0]  = mk(OP_RD_FILT, 8'd0, 8'd1, 8'd1, 8'd0,  1'b1, 8'h2A, 1'b0);
    vecs[1]  = mk(OP_RD_FILT, 8'd0, 8'd2, 8'd2, 8'd0,  1'b1, 8'hF0, 1'b0);
    vecs[2]  = mk(OP_RD_FILT, 8'd0, 8'd3, 8'd0, 8'd0,  1'b1, 8'h00, 1'b1);
    vecs[3]  = mk(OP_RD_FILT, 8'd1, 8'd0, 8'd0, 8'd0,  1'b1, 8'h00, 1'b1);
    vecs[4]  = mk(OP_WR_VPOT, 8'd0, 8'd2, 8'd2, 8'd77, 1'b0, 8'h00, 1'b0);
    vecs[5]  = mk(OP_RD_VPOT, 8'd0, 8'd2, 8'd2, 8'd0,  1'b1, 8'd77, 1'b0);
    vecs[6]  = mk(OP_RD_VPOT, 8'd0, 8'd3, 8'd0, 8'd0,  1'b1, 8'h00, 1'b1);
    vecs[7]  = mk(OP_WR_VPOT, 8'd0, 8'd0, 8'd3, 8'd99, 1'b0, 8'h00, 1'b0);
    vecs[8]  = mk(OP_RD_VPOT, 8'd0, 8'd1, 8'd0, 8'd0,  1'b1, 8'h00, 1'b0);
    vecs[9]  = mk(OP_WR_VPOT, 8'd0, 8'd0, 8'd0, 8'hFF, 1'b0, 8'h00, 1'b0);
    vecs[10] = mk(OP_RD_VPOT, 8'd0, 8'd0, 8'd0, 8'd0,  1'b1, 8'hFF, 1'b0);
    vecs[11] = mk(OP_RD_OSPK, 8'd0, 8'd1, 8'd1, 8'd0,  1'b1, 8'h00, 1'b0);
    vecs[12] = mk(OP_RD_ISPK, 8'd0, 8'd3, 8'd4, 8'd0,  1'b1, 8'h00, 1'b0);
    vecs[13] = mk(OP_RD_ISPK, 8'd0, 8'd5, 8'd0, 8'd0,  1'b1, 8'h00, 1'b1);
    vecs[14] = mk(3'd6,       8'd0, 8'd0, 8'd0, 8'd0,  1'b1, 8'h00, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ts", 32'(ts), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", 32'(req_ready), 32'd1);
    check("post-rst ts_ready", 32'(ts_ready), 32'd1);

    // Preloads; the out-of-range addresses alias onto real entries if the
    // range check were missing (20 -> filter 4, 300 -> ifmap 44).
    preload(1'b0, 16'd0,   8'h11);
    preload(1'b0, 16'd4,   8'h2A);
    preload(1'b0, 16'd8,   8'hF0);
    preload(1'b0, 16'd20,  8'hEE);
    preload(1'b1, 16'd19,  8'h00);
    preload(1'b1, 16'd25,  8'h00);
    preload(1'b1, 16'd44,  8'h01);
    preload(1'b1, 16'd300, 8'h00);

    // Table-driven vectors at ts = 0
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].op, vecs[i].ch, vecs[i].row, vecs[i].col, vecs[i].wdata, 1'b0,
           vecs[i].rd, vecs[i].exp_data, vecs[i].exp_err);
      if (vecs[i].rd) get_rsp($sformatf("vec%0d", i), 0);
    end

    // Response held stable with rsp_ready low for 3 cycles
    send(OP_RD_VPOT, 8'd0, 8'd2, 8'd2, 8'd0, 1'b0, 1'b1, 8'd77, 1'b0);
    get_rsp("vpot hold", 3);

    // Preload and read of the same filter entry in one cycle: old value
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 16'd0; ld_data = 8'h55;
    send(OP_RD_FILT, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 8'h11, 1'b0);
    ld_valid = 1'b0;
    get_rsp("filt collide old", 0);
    rd("filt collide new", OP_RD_FILT, 8'd0, 8'd0, 8'd0, 8'h55, 1'b0);

    // Spike write together with a ts advance lands at t=0, not t=1
    send(OP_WR_OSPK, 8'd0, 8'd1, 8'd1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    check("ts after adv", 32'(ts), 32'd1);
    rd("ospk t1", OP_RD_OSPK, 8'd0, 8'd1, 8'd1, 8'h00, 1'b0);

    // Ifmap reads at t=1
    rd("ispk t1 (3,4)", OP_RD_ISPK, 8'd0, 8'd3, 8'd4, 8'h01, 1'b0);
    rd("ispk t1 (0,0)", OP_RD_ISPK, 8'd0, 8'd0, 8'd0, 8'h00, 1'b0);

    // Advance to the end: one advance already done, nine more reach DONE
    adv = 0;
    while (!done && adv < 20) begin
      ts_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      adv++;
    end
    ts_valid = 1'b0;
    check("advances to done", 32'(adv), 32'd9);
    check("done", 32'(done), 32'd1);
    check("done ts", 32'(ts), 32'd9);
    check("done req_ready", 32'(req_ready), 32'd0);
    check("done ts_ready", 32'(ts_ready), 32'd0);
    ts_valid = 1'b1;
    @(negedge clk);
    ts_valid = 1'b0;
    check("done ts holds", 32'(ts), 32'd9);
    check("done sticky", 32'(done), 32'd1);

    // Asynchronous reset out of DONE
    #2 rst_n = 1'b0;
    #1;
    check("async rst ts", 32'(ts), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("ospk cleared", OP_RD_OSPK, 8'd0, 8'd1, 8'd1, 8'h00, 1'b0);
    rd("vpot cleared", OP_RD_VPOT, 8'd0, 8'd2, 8'd2, 8'h00, 1'b0);
    rd("filt retained", OP_RD_FILT, 8'd0, 8'd1, 8'd1, 8'h2A, 1'b0);

    // Read together with a ts advance uses the pre-increment timestep
    send(OP_WR_OSPK, 8'd0, 8'd2, 8'd1, 8'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    send(OP_RD_OSPK, 8'd0, 8'd2, 8'd1, 8'd0, 1'b1, 1'b1, 8'h01, 1'b0);
    get_rsp("ospk pre-inc t0", 0);
    check("ts after rd adv", 32'(ts), 32'd1);
    rd("ospk t1 empty", OP_RD_OSPK, 8'd0, 8'd2, 8'd1, 8'h00, 1'b0);

    // Reset during RESP discards the pending response
    send(OP_RD_FILT, 8'd0, 8'd1, 8'd1, 8'd0, 1'b0, 1'b1, 8'h2A, 1'b0);
    check("resp pending", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid-resp valid", 32'(rsp_valid), 32'd0);
    check("rst mid-resp data", 32'(rsp_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after rst no rsp", 32'(rsp_valid), 32'd0);
    check("after rst req_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snn_mem_ctrl.md
SNN_MEM_CTRL -- requirements
Module: snn_mem_ctrl

Interface
REQ-001 Parameter TIMESTEPS, 10, number of simulation timesteps.
REQ-002 Parameter NUM_CH, 1, number of filter/output channels.
REQ-003 Parameter IF_ROWS, IF_COLS, 5/5, input-spike map size.
REQ-004 Parameter F_ROWS, F_COLS, 3/3, filter size.
REQ-005 Parameter OF_ROWS, OF_COLS, 3/3, output map size.
REQ-006 Parameter F_WIDTH, 8, filter word width.
REQ-007 Parameter V_WIDTH, 8, membrane-potential width.
REQ-008 One clock; reset is asynchronous and active-low.
REQ-009 Ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-010 Ports: ld_valid in 1, ld_sel in 1 (0 = filter, 1 = ifmap), ld_addr in 16, ld_data in F_WIDTH; preload port, writes always accepted.
REQ-011 Ports: req_valid in 1, req_ready out 1, req_op in 3, req_ch in 8, req_row in 8, req_col in 8, req_wdata in V_WIDTH.
REQ-012 Ports: rsp_valid out 1, rsp_ready in 1, rsp_data out max(F_WIDTH,V_WIDTH), rsp_err out 1.
REQ-013 Ports: ts_valid in 1, ts_ready out 1, ts out clog2(TIMESTEPS) (current timestep), done out 1.

Function
REQ-014 req_op encoding: 0 RD_VPOT, 1 RD_ISPK, 2 RD_FILT, 3 WR_VPOT, 4 WR_OSPK, 5 RD_OSPK; codes 6-7 are illegal.
REQ-015 Address indexing: VPOT/OSPK use [ch][row][col]; FILT uses [ch][row][col]; ISPK uses [ts][row][col].
REQ-016 FSM states: IDLE, RESP, DONE.
REQ-017 req_ready is 1 only in IDLE.
REQ-018 A read accepted in cycle N registers the response and drives rsp_valid=1 in cycle N+1; the FSM enters RESP.
REQ-019 In RESP, rsp_valid, rsp_data and rsp_err hold stable until rsp_ready=1; the FSM then returns to IDLE on the next edge.
REQ-020 Writes complete in the accept cycle and produce no response; the FSM stays in IDLE.
REQ-021 WR_OSPK sets bit of_mem[ts][ch][row][col] to 1; req_wdata is ignored.
REQ-022 RD_ISPK and RD_OSPK return the bit zero-extended, including 0-valued spikes.
REQ-023 An out-of-range ch/row/col, or an illegal op, on a read returns rsp_err=1 with rsp_data=0.
REQ-024 An out-of-range write, or an illegal-op write, is dropped; no response and no state change.
REQ-025 Timestep advance: ts_ready=1 in IDLE and RESP; an accepted ts_valid increments ts.
REQ-026 Accepting ts_valid when ts=TIMESTEPS-1 instead asserts done=1 and moves to DONE; ts holds its value.
REQ-027 Simultaneous request and ts advance in the same cycle: the request uses the pre-increment ts.
REQ-028 In DONE: req_ready=0, ts_ready=0, done=1; only reset exits DONE.
REQ-029 Preload: ld_sel=0 writes flat filter address ch*F_ROWS*F_COLS + row*F_COLS + col; ld_sel=1 writes flat ifmap address t*IF_ROWS*IF_COLS + row*IF_COLS + col using ld_data[0].
REQ-030 Out-of-range ld_addr is ignored.
REQ-031 A preload and a read of the same location in the same cycle returns the old value.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, ts=0, done=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-033 On rst_n=0, asynchronously: all of_mem and V_pot bits are cleared to 0; filter and ifmap contents are retained.
REQ-034 Reset asserted mid-RESP discards the pending response.
REQ-035 Outputs are valid from the first clock edge after rst_n deasserts.

Structure
REQ-036 Package snn_mem_pkg holds the req_op enum, the state enum and the default dimension constants.
REQ-037 One sub-module, snn_mem_bank, is a parametrised sync-write/registered-read array instantiated for the filter, ifmap, V_pot and of_mem storage.

Verification
REQ-038 Preload filter ch0 addr 4 = 8'h2A; RD_FILT (0,1,1) -> rsp_valid next cycle, rsp_data=8'h2A, rsp_err=0.
REQ-039 WR_VPOT (0,2,2) with data 8'd77, then RD_VPOT (0,2,2) -> 77; hold rsp_ready=0 for 3 cycles -> response remains stable.
REQ-040 Preload ifmap bit at t=1, (3,4) = 1; advance ts once; RD_ISPK (3,4) -> 1; RD_ISPK (0,0) -> 0.
REQ-041 RD_VPOT row=3 (OF_ROWS=3) -> rsp_err=1, data=0; out-of-range WR_VPOT followed by in-range read -> unchanged value.
REQ-042 Issue WR_OSPK (0,1,1) in the same cycle as a ts advance at ts=0 -> RD_OSPK at t=0 reads 1 and at t=1 reads 0.
REQ-043 Advance ts 10 times (TIMESTEPS=10) -> done=1 and req_ready=0; assert rst_n=0 -> ts=0, done=0, of_mem cleared.
